viterbi_decoder: RTL and testbench
==================================

VITERBI_DECODER -- requirements
Module: viterbi_decoder

Interface
REQ-001 Parameter TB_DEPTH, default 16, survivor length in symbols (legal 8..32).
REQ-002 Parameter METRIC_W, default 6, path-metric width in bits.
REQ-003 Port clk  input  1  single clock, all state updates on rising edge.
REQ-004 Port rst  input  1  asynchronous active-low reset.
REQ-005 Port enable  input  1  high marks d_in as a valid code symbol this cycle.
REQ-006 Port d_in  input  2  hard-decision code symbol, [1]=G0 bit, [0]=G1 bit.
REQ-007 Port d_out  output  1  registered decoded data bit.

Function
REQ-008 Code SHALL be rate 1/2, K=3, generators G0=111, G1=101; encoder state s={u[n-1],u[n-2]}, out[1]=u^s[1]^s[0], out[0]=u^s[0], next state {u,s[1]}.
REQ-009 Trellis SHALL have 4 states; state ns={b,x} has predecessors {x,0} and {x,1}, input bit b.
REQ-010 Branch metric SHALL be Hamming distance (0..2) between d_in and the branch output.
REQ-011 On each enable cycle every state SHALL add-compare-select: candidate = PM[pred]+BM; keep smaller; on tie keep predecessor with lower index.
REQ-012 After ACS, minimum new metric SHALL be subtracted from all four new metrics (no overflow for METRIC_W>=4).
REQ-013 Survivors SHALL use register exchange: surv[ns] <= {surv[winner][TB_DEPTH-2:0], b}, TB_DEPTH bits each.
REQ-014 On each enable cycle d_out SHALL load surv[best][TB_DEPTH-1] using pre-update metrics and survivors; best = minimum metric, lowest index on tie.
REQ-015 Latency: at the edge of the k-th enable after reset, d_out SHALL equal the data bit of symbol k-TB_DEPTH; for k<=TB_DEPTH d_out=0.
REQ-016 With enable low all metrics, survivors and d_out SHALL hold; gaps of any length SHALL not alter decoding.
REQ-017 Decoder SHALL never lock up; after any error burst it SHALL return to correct output once 2*TB_DEPTH clean symbols follow.

Reset
REQ-018 rst low SHALL asynchronously force d_out=0, all survivors=0, PM[0]=0, PM[1..3]=2**(METRIC_W-1)-1.
REQ-019 Reset mid-stream SHALL discard all history; next enable is symbol 1 from encoder state 00.

Configuration
REQ-020 Macro VITERBI_METRIC_OUT_EN defined: extra output best_metric[METRIC_W-1:0], registered on enable with the pre-update minimum metric (0 after reset); macro undefined: port and logic absent, all other behaviour identical.

Structure
REQ-021 Package viterbi_pkg SHALL hold K, NUM_STATES=4, G0, G1, state_t (2 bits), metric_t (METRIC_W-independent max 8 bits used via slicing) and function branch_out(state,bit).
REQ-022 One sub-module viterbi_acs (two candidate metrics in, selected metric and decision bit out, combinational) instantiated once per state.
REQ-023 A matching encoder (clk, rst, enable_i, d_in, valid_o, d_out[1:0]) per REQ-008, valid_o = registered enable_i, is bench-side stimulus, not part of this block.

Verification
REQ-024 Reset: hold rst low, toggle enable/d_in -> d_out=0, best_metric=0.
REQ-025 All-zero symbols d_in=00 for 100 enables -> d_out=0 throughout, best_metric=0.
REQ-026 Clean: 256 LFSR bits through encoder -> d_out equals input delayed TB_DEPTH enables, 0 mismatches.
REQ-027 Both bits of one symbol inverted every 32nd symbol, 256 symbols -> 0 mismatches.
REQ-028 Two consecutive symbols inverted every 32nd/31st positions -> no lockup, mismatches confined to within 2*TB_DEPTH of each burst, mismatch count reported.
REQ-029 Random enable gaps (1-5 idle cycles) on clean stream, plus rst pulse mid-stream -> output sequence identical to gapless run; post-reset d_out=0 for TB_DEPTH enables then correct.

Source files
------------

// File: rtl/viterbi_pkg.sv
// Shared constants, types and the trellis branch-output helper for the
// K=3, rate 1/2 (G0=111, G1=101) hard-decision Viterbi decoder.
package viterbi_pkg;

  localparam int K          = 3;
  localparam int NUM_STATES = 4;

  localparam logic [K-1:0] G0 = 3'b111;
  localparam logic [K-1:0] G1 = 3'b101;

  // Encoder state {u[n-1], u[n-2]}
  typedef logic [1:0] state_t;

  // Widest metric supported; users slice down to METRIC_W bits
  typedef logic [7:0] metric_t;

  // Code symbol {G0 bit, G1 bit} emitted when bit b enters state s
  function automatic logic [1:0] branch_out(input state_t s, input logic b);
    logic [K-1:0] taps;
    taps = {b, s};
    return {^(taps & G0), ^(taps & G1)};
  endfunction

endpackage

// File: rtl/viterbi_decoder_if.sv
// Symbol stream in / decoded bit out bundle for viterbi_decoder.
// Handshake: a symbol is consumed on every rising clk edge where enable is
// high; there is no back-pressure, the decoder accepts one symbol per cycle.
// Optional best_metric port exists only when VITERBI_METRIC_OUT_EN is defined.
interface viterbi_decoder_if
`ifdef VITERBI_METRIC_OUT_EN
  #(parameter int METRIC_W = 6)
`endif
  ;

  logic       enable;
  logic [1:0] d_in;
  logic       d_out;
`ifdef VITERBI_METRIC_OUT_EN
  logic [METRIC_W-1:0] best_metric;
`endif

`ifdef VITERBI_METRIC_OUT_EN
  modport master (output enable, output d_in, input d_out, input best_metric);
  modport slave  (input enable, input d_in, output d_out, output best_metric);
`else
  modport master (output enable, output d_in, input d_out);
  modport slave  (input enable, input d_in, output d_out);
`endif

endinterface

// File: rtl/viterbi_acs.sv
// Compare-select for one trellis state: picks the smaller of two candidate
// path metrics; on a tie the lower-index predecessor (cand0) wins.
module viterbi_acs
  import viterbi_pkg::*;
#(
  parameter int METRIC_W = 6
) (
  input  logic [METRIC_W-1:0] cand0,
  input  logic [METRIC_W-1:0] cand1,
  output logic [METRIC_W-1:0] metric,
  output logic                dec
);

  // Select strictly smaller candidate so ties resolve toward cand0
  always_comb begin
    dec    = (cand1 < cand0);
    metric = dec ? cand1 : cand0;
  end

endmodule

// File: rtl/viterbi_decoder.sv
// Hard-decision Viterbi decoder, K=3 rate 1/2, register-exchange survivors.
// Output d_out at the k-th enable is the decision for symbol k-TB_DEPTH,
// taken from the best pre-update path. Optional macro VITERBI_METRIC_OUT_EN
// adds a registered best_metric output.
module viterbi_decoder
  import viterbi_pkg::*;
#(
  parameter int TB_DEPTH = 16,
  parameter int METRIC_W = 6
) (
  input logic             clk,
  input logic             rst,
  viterbi_decoder_if.slave bus
);

  // Non-zero start states are penalised so decoding begins from state 00
  localparam metric_t                PM_INIT_FULL = metric_t'((1 << (METRIC_W - 1)) - 1);
  localparam logic [METRIC_W-1:0]    PM_INIT      = PM_INIT_FULL[METRIC_W-1:0];

  logic [METRIC_W-1:0] pm        [NUM_STATES];
  logic [TB_DEPTH-1:0] surv      [NUM_STATES];
  logic [METRIC_W-1:0] acs_metric[NUM_STATES];
  logic [METRIC_W-1:0] norm_pm   [NUM_STATES];
  logic [TB_DEPTH-1:0] next_surv [NUM_STATES];
  logic                dec       [NUM_STATES];
  state_t              winner    [NUM_STATES];
  logic [METRIC_W-1:0] min_new;
  state_t              best;
  logic [METRIC_W-1:0] best_pm;
  logic                d_out_q;

  function automatic logic [METRIC_W-1:0] hamming(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] x;
    x = a ^ b;
    return METRIC_W'(x[1]) + METRIC_W'(x[0]);
  endfunction

  // State ns={b,x} is entered from {x,0} and {x,1} with input bit b
  for (genvar gs = 0; gs < NUM_STATES; gs++) begin : g_acs
    localparam state_t P0     = state_t'((gs % 2) * 2);
    localparam state_t P1     = state_t'((gs % 2) * 2 + 1);
    localparam logic   IN_BIT = (gs >= 2);

    logic [METRIC_W-1:0] cand0;
    logic [METRIC_W-1:0] cand1;

    assign cand0 = pm[P0] + hamming(bus.d_in, branch_out(P0, IN_BIT));
    assign cand1 = pm[P1] + hamming(bus.d_in, branch_out(P1, IN_BIT));

    viterbi_acs #(.METRIC_W(METRIC_W)) u_acs (
      .cand0  (cand0),
      .cand1  (cand1),
      .metric (acs_metric[gs]),
      .dec    (dec[gs])
    );

    assign winner[gs]    = dec[gs] ? P1 : P0;
    assign next_surv[gs] = {surv[winner[gs]][TB_DEPTH-2:0], IN_BIT};
  end

  // Normalise new metrics so the smallest is zero and nothing can wrap
  always_comb begin
    min_new = acs_metric[0];
    for (int i = 1; i < NUM_STATES; i++) begin
      if (acs_metric[i] < min_new) min_new = acs_metric[i];
    end
    for (int i = 0; i < NUM_STATES; i++) begin
      norm_pm[i] = acs_metric[i] - min_new;
    end
  end

  // Best pre-update state; strict compare keeps the lowest index on a tie
  always_comb begin
    best    = '0;
    best_pm = pm[0];
    for (int i = 1; i < NUM_STATES; i++) begin
      if (pm[i] < best_pm) begin
        best    = state_t'(i);
        best_pm = pm[i];
      end
    end
  end

  // Metric, survivor and output registers advance only on enabled symbols
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pm[0]   <= '0;
      surv[0] <= '0;
      for (int i = 1; i < NUM_STATES; i++) begin
        pm[i]   <= PM_INIT;
        surv[i] <= '0;
      end
      d_out_q <= 1'b0;
    end else if (bus.enable) begin
      for (int i = 0; i < NUM_STATES; i++) begin
        pm[i]   <= norm_pm[i];
        surv[i] <= next_surv[i];
      end
      d_out_q <= surv[best][TB_DEPTH-1];
    end
  end

  assign bus.d_out = d_out_q;

`ifdef VITERBI_METRIC_OUT_EN
  logic [METRIC_W-1:0] best_metric_q;

  // Minimum metric seen before this symbol's update
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      best_metric_q <= '0;
    end else if (bus.enable) begin
      best_metric_q <= best_pm;
    end
  end

  assign bus.best_metric = best_metric_q;
`endif

endmodule

// File: tb/tb_viterbi_decoder.sv
// Self-checking bench for viterbi_decoder. A behavioural convolutional
// encoder produces symbols from random/LFSR data; the expected decoded bit is
// the source bit delayed TB_DEPTH enables (zeros right after reset).
module tb_viterbi_decoder;

  localparam int TB_DEPTH = 16;
  localparam int METRIC_W = 6;
  localparam int N_SYM    = 256;

  logic clk = 1'b0;
  logic rst = 1'b0;

`ifdef VITERBI_METRIC_OUT_EN
  viterbi_decoder_if #(.METRIC_W(METRIC_W)) bus ();
`else
  viterbi_decoder_if bus ();
`endif

  viterbi_decoder #(.TB_DEPTH(TB_DEPTH), .METRIC_W(METRIC_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock
  always #5 clk = ~clk;

  // Scoreboard state
  int         n_checks = 0;
  int         n_errors = 0;
  logic [0:0] exp_q[$];
  int         src_q[$];
  logic       enc_u1, enc_u2;
  int         sym_idx;
  logic [15:0] lfsr;
  logic       last_obs, last_exp;
  int         last_src;
  int         burst_mis;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // Reference model restart: encoder back to 00, TB_DEPTH zero outputs due
  task automatic model_reset();
    enc_u1 = 1'b0;
    enc_u2 = 1'b0;
    sym_idx = 0;
    exp_q.delete();
    src_q.delete();
    repeat (TB_DEPTH) begin
      exp_q.push_back(1'b0);
      src_q.push_back(-1);
    end
    last_exp = 1'b0;
  endtask

  task automatic apply_reset(input int cycles);
    @(negedge clk);
    rst = 1'b0;
    bus.enable = 1'b0;
    bus.d_in = 2'($urandom_range(3, 0));
    #1;
    chk("reset_async_dout", 32'(bus.d_out), 32'd0);
    repeat (cycles) @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  // Encode one data bit (optionally corrupting it) and present it for one edge
  task automatic send(input logic u, input logic [1:0] flip);
    logic [2:0]  window;
    logic [1:0]  sym;
    window = {u, enc_u1, enc_u2};
    sym    = {^(window & 3'b111), ^(window & 3'b101)};
    enc_u2 = enc_u1;
    enc_u1 = u;
    exp_q.push_back(u);
    src_q.push_back(sym_idx);
    sym_idx++;
    @(negedge clk);
    bus.enable = 1'b1;
    bus.d_in   = sym ^ flip;
    @(posedge clk);
    #1;
    last_obs = bus.d_out;
    last_exp = exp_q.pop_front();
    last_src = src_q.pop_front();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.enable = 1'b0;
      bus.d_in   = 2'($urandom_range(3, 0));
      @(posedge clk);
      #1;
      chk("gap_hold", 32'(bus.d_out), 32'(last_exp));
    end
  endtask

  task automatic send_clean(input string tag);
    lfsr = lfsr_step(lfsr);
    send(lfsr[0], 2'b00);
    chk(tag, 32'(last_obs), 32'(last_exp));
`ifdef VITERBI_METRIC_OUT_EN
    chk({tag, "_metric"}, 32'(bus.best_metric), 32'd0);
`endif
  endtask

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] seed;
    logic        ok;
    bus.enable = 1'b0;
    bus.d_in   = 2'b00;
    rst        = 1'b0;
    model_reset();

    // Reset held: inputs toggle but nothing moves
    repeat (6) begin
      @(negedge clk);
      bus.enable = 1'($urandom_range(1, 0));
      bus.d_in   = 2'($urandom_range(3, 0));
      @(posedge clk);
      #1;
      chk("reset_hold_dout", 32'(bus.d_out), 32'd0);
`ifdef VITERBI_METRIC_OUT_EN
      chk("reset_hold_metric", 32'(bus.best_metric), 32'd0);
`endif
    end
    @(negedge clk);
    bus.enable = 1'b0;
    rst = 1'b1;
    model_reset();

    // All-zero stream
    for (int i = 0; i < 100; i++) begin
      send(1'b0, 2'b00);
      chk("zeros_dout", 32'(last_obs), 32'd0);
`ifdef VITERBI_METRIC_OUT_EN
      chk("zeros_metric", 32'(bus.best_metric), 32'd0);
`endif
    end

    // Clean LFSR stream
    apply_reset(2);
    lfsr = 16'($urandom_range(65535, 1));
    for (int i = 0; i < N_SYM; i++) send_clean("clean");

    // One fully inverted symbol every 32: must be corrected
    apply_reset(2);
    for (int i = 0; i < N_SYM; i++) begin
      lfsr = lfsr_step(lfsr);
      send(lfsr[0], (i % 32 == 31) ? 2'b11 : 2'b00);
      chk("single_err", 32'(last_obs), 32'(last_exp));
    end

    // Two-symbol bursts, then a clean tail that must decode exactly
    apply_reset(2);
    burst_mis = 0;
    for (int i = 0; i < N_SYM + 4 * TB_DEPTH; i++) begin
      lfsr = lfsr_step(lfsr);
      send(lfsr[0], (i < N_SYM && (i % 32 == 30 || i % 32 == 31)) ? 2'b11 : 2'b00);
      if (last_src >= 0 && last_obs !== last_exp) begin
        burst_mis++;
        ok = 1'b0;
        for (int b = 30; b < N_SYM; b += 32) begin
          if (last_src >= b - 2 * TB_DEPTH && last_src <= b + 1 + 2 * TB_DEPTH) ok = 1'b1;
        end
        chk("burst_confined", 32'(ok), 32'd1);
      end
      if (last_src >= N_SYM + 2 * TB_DEPTH) chk("burst_recover", 32'(last_obs), 32'(last_exp));
    end
    $display("burst test decoded-bit mismatches: %0d", burst_mis);

    // Gapless reference run, then same data with random gaps and a reset
    apply_reset(2);
    seed = 16'($urandom_range(65535, 1));
    lfsr = seed;
    for (int i = 0; i < N_SYM; i++) send_clean("gapless");
    apply_reset(3);
    lfsr = seed;
    for (int i = 0; i < N_SYM; i++) begin
      if (i == N_SYM / 2) apply_reset(1 + $urandom_range(3, 0));
      send_clean("gapped");
      idle($urandom_range(5, 1));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
